// File: rtl/mil1553_word_rx.sv
// MIL-STD-1553 word receiver: hunts for a command/data sync in a Manchester half-bit
// stream and decodes one word. Define MIL1553_RX_PARITY_EN to add the odd-parity check.
module mil1553_word_rx #(
    parameter int DATA_BITS = 16,
    parameter int SYNC_HALF = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_rx_in,
    input  logic                 i_rx_valid,
    input  logic                 i_clear,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic                 o_fail,
    output logic [1:0]           o_err,
    output logic                 o_word_type,
    output logic [DATA_BITS-1:0] o_data
);

    // state  | meaning
    // S_HUNT | shifting half-bits into the sync window
    // S_DATA | decoding Manchester data pairs
    // S_PAR  | decoding and checking the parity pair
    // S_DONE | one-cycle o_valid pulse
    // S_FAIL | one-cycle o_fail pulse
    localparam int WW = 2 * SYNC_HALF;
    localparam int FW = $clog2(WW + 1);
    localparam int HW = $clog2(2 * DATA_BITS + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(WW);
    localparam logic [HW-1:0] HCNT_END  = HW'(2 * DATA_BITS);
    localparam logic [WW-1:0] CMD_SYNC  = {{SYNC_HALF{1'b1}}, {SYNC_HALF{1'b0}}};
    localparam logic [WW-1:0] DAT_SYNC  = ~CMD_SYNC;

    typedef enum logic [2:0] {
        S_HUNT,
        S_DATA,
`ifdef MIL1553_RX_PARITY_EN
        S_PAR,
`endif
        S_DONE,
        S_FAIL
    } state_t;

    state_t               state, state_n;
    logic [WW-1:0]        win, win_n, win_sh;
    logic [FW-1:0]        fill, fill_n, fill_inc;
    logic [HW-1:0]        hcnt, hcnt_n;
    logic [DATA_BITS-1:0] sreg, sreg_n, sreg_sh, data_n;
    logic                 first, first_n;
    logic                 wtype_n;
    logic [1:0]           err_n;
    logic                 pair_ok;
    logic                 sync_hit;
`ifdef MIL1553_RX_PARITY_EN
    logic                 par, par_n;
    logic                 ph, ph_n;
`endif

    assign win_sh   = (win << 1) | WW'(i_rx_in);
    assign fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
    assign sync_hit = (fill_inc == FILL_FULL) && ((win_sh == CMD_SYNC) || (win_sh == DAT_SYNC));
    // the first half of a valid pair is the decoded bit (10 = 1, 01 = 0)
    assign pair_ok  = first ^ i_rx_in;
    assign sreg_sh  = (sreg << 1) | DATA_BITS'(first);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= S_HUNT;
            win         <= '0;
            fill        <= '0;
            hcnt        <= '0;
            sreg        <= '0;
            first       <= 1'b0;
            o_word_type <= 1'b0;
            o_err       <= 2'b00;
            o_data      <= '0;
`ifdef MIL1553_RX_PARITY_EN
            par         <= 1'b0;
            ph          <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            win         <= win_n;
            fill        <= fill_n;
            hcnt        <= hcnt_n;
            sreg        <= sreg_n;
            first       <= first_n;
            o_word_type <= wtype_n;
            o_err       <= err_n;
            o_data      <= data_n;
`ifdef MIL1553_RX_PARITY_EN
            par         <= par_n;
            ph          <= ph_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        win_n   = win;
        fill_n  = fill;
        hcnt_n  = hcnt;
        sreg_n  = sreg;
        first_n = first;
        wtype_n = o_word_type;
        err_n   = o_err;
        data_n  = o_data;
`ifdef MIL1553_RX_PARITY_EN
        par_n   = par;
        ph_n    = ph;
`endif
        if (i_clear) begin
            state_n = S_HUNT;
            win_n   = '0;
            fill_n  = '0;
            hcnt_n  = '0;
            sreg_n  = '0;
            first_n = 1'b0;
`ifdef MIL1553_RX_PARITY_EN
            par_n   = 1'b0;
            ph_n    = 1'b0;
`endif
        end else begin
            case (state)
                S_HUNT: if (i_rx_valid) begin
                    win_n  = win_sh;
                    fill_n = fill_inc;
                    if (sync_hit) begin
                        wtype_n = (win_sh == DAT_SYNC);
                        win_n   = '0;
                        fill_n  = '0;
                        hcnt_n  = '0;
                        sreg_n  = '0;
`ifdef MIL1553_RX_PARITY_EN
                        par_n   = 1'b0;
                        ph_n    = 1'b0;
`endif
                        state_n = S_DATA;
                    end
                end
                S_DATA: if (i_rx_valid) begin
                    hcnt_n = hcnt + HW'(1);
                    if (!hcnt[0]) begin
                        first_n = i_rx_in;
                    end else if (!pair_ok) begin
                        err_n   = 2'b01;
                        state_n = S_FAIL;
                    end else begin
                        sreg_n = sreg_sh;
`ifdef MIL1553_RX_PARITY_EN
                        par_n  = par ^ first;
                        if (hcnt_n == HCNT_END) state_n = S_PAR;
`else
                        if (hcnt_n == HCNT_END) begin
                            data_n  = sreg_sh;
                            err_n   = 2'b00;
                            state_n = S_DONE;
                        end
`endif
                    end
                end
`ifdef MIL1553_RX_PARITY_EN
                S_PAR: if (i_rx_valid) begin
                    ph_n = ~ph;
                    if (!ph) begin
                        first_n = i_rx_in;
                    end else if (!pair_ok) begin
                        err_n   = 2'b01;
                        state_n = S_FAIL;
                    end else if (!(par ^ first)) begin
                        err_n   = 2'b10;
                        state_n = S_FAIL;
                    end else begin
                        data_n  = sreg;
                        err_n   = 2'b00;
                        state_n = S_DONE;
                    end
                end
`endif
                S_DONE:  state_n = S_HUNT;
                S_FAIL:  state_n = S_HUNT;
                default: state_n = S_HUNT;
            endcase
        end
    end

`ifdef MIL1553_RX_PARITY_EN
    assign o_busy  = (state == S_DATA) || (state == S_PAR);
`else
    assign o_busy  = (state == S_DATA);
`endif
    assign o_valid = (state == S_DONE);
    assign o_fail  = (state == S_FAIL);

endmodule

// File: tb/tb_mil1553_word_rx.sv
// Bench for mil1553_word_rx: directed and random words checked against a word-level
// reference model. Follows MIL1553_RX_PARITY_EN the same way as the design.
`timescale 1ns/1ps
module tb_mil1553_word_rx;
    localparam int DB = 16;
    localparam int SH = 3;
`ifdef MIL1553_RX_PARITY_EN
    localparam int NPAIRS = DB + 1;
`else
    localparam int NPAIRS = DB;
`endif

    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_rx_in;
    logic          i_rx_valid;
    logic          i_clear;
    logic          o_busy;
    logic          o_valid;
    logic          o_fail;
    logic [1:0]    o_err;
    logic          o_word_type;
    logic [DB-1:0] o_data;

    mil1553_word_rx #(.DATA_BITS(DB), .SYNC_HALF(SH)) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_rx_in     (i_rx_in),
        .i_rx_valid  (i_rx_valid),
        .i_clear     (i_clear),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .o_fail      (o_fail),
        .o_err       (o_err),
        .o_word_type (o_word_type),
        .o_data      (o_data)
    );

    always #5 i_clk = ~i_clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DB-1:0] exp_data;
    logic [1:0]    exp_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at edge+1 with i_rx_valid low; returns at edge+1 after the accepting edge.
    task automatic send_hb(input logic b, input int gap);
        repeat (gap) begin @(posedge i_clk); #1; end
        i_rx_in    = b;
        i_rx_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rx_valid = 1'b0;
    endtask

    task automatic send_sync(input logic dtype, input int maxgap, input string tag);
        check({tag, "_idle_busy"}, o_busy, 1'b0);
        for (int i = 0; i < 2 * SH; i++)
            send_hb((i < SH) ? ~dtype : dtype, $urandom_range(0, maxgap));
        check({tag, "_sync_busy"}, o_busy, 1'b1);
        check({tag, "_sync_type"}, o_word_type, dtype);
    endtask

    task automatic run_word(input logic dtype, input logic [DB-1:0] data, input int bad_idx,
                            input logic [1:0] bad_val, input logic par_flip,
                            input int maxgap, input string tag);
        logic [1:0]    pairs[$];
        logic [DB-1:0] dec;
        logic          ev, ef, pb;
        logic [1:0]    ee;
        int            stop, ones;
        for (int i = DB - 1; i >= 0; i--) pairs.push_back(data[i] ? 2'b10 : 2'b01);
`ifdef MIL1553_RX_PARITY_EN
        pb = ((($countones(data) % 2) == 0) ? 1'b1 : 1'b0) ^ par_flip;
        pairs.push_back(pb ? 2'b10 : 2'b01);
`else
        pb = par_flip;
`endif
        if (bad_idx >= 0 && bad_idx < pairs.size()) pairs[bad_idx] = bad_val;
        ev = 1'b0; ef = 1'b0; ee = 2'b00; dec = '0; ones = 0;
        stop = pairs.size() - 1;
        for (int k = 0; k < pairs.size(); k++) begin
            if (pairs[k] == 2'b00 || pairs[k] == 2'b11) begin
                ef = 1'b1; ee = 2'b01; stop = k;
                break;
            end
            ones += int'(pairs[k][1]);
            if (k < DB) dec = {dec[DB-2:0], pairs[k][1]};
        end
        if (!ef) begin
            ev = 1'b1;
`ifdef MIL1553_RX_PARITY_EN
            if ((ones % 2) == 0) begin ev = 1'b0; ef = 1'b1; ee = 2'b10; end
`endif
        end
        send_sync(dtype, maxgap, tag);
        for (int k = 0; k <= stop; k++) begin
            send_hb(pairs[k][1], $urandom_range(0, maxgap));
            send_hb(pairs[k][0], $urandom_range(0, maxgap));
        end
        check({tag, "_valid"}, o_valid, ev);
        check({tag, "_fail"},  o_fail,  ef);
        check({tag, "_err"},   o_err,   ee);
        check({tag, "_data"},  o_data,  ev ? dec : exp_data);
        check({tag, "_type"},  o_word_type, dtype);
        check({tag, "_busy"},  o_busy,  1'b0);
        exp_err = ee;
        if (ev) exp_data = dec;
        @(posedge i_clk); #1;
        check({tag, "_valid_off"}, o_valid, 1'b0);
        check({tag, "_fail_off"},  o_fail,  1'b0);
        check({tag, "_err_hold"},  o_err,   exp_err);
        check({tag, "_data_hold"}, o_data,  exp_data);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    logic [DB-1:0] rd;
    int            rmode, ridx;
    logic [1:0]    rbad;

    initial begin
        i_reset_n = 1'b0; i_rx_in = 1'b0; i_rx_valid = 1'b0; i_clear = 1'b0;
        exp_data = '0; exp_err = 2'b00;
        repeat (3) @(posedge i_clk); #1;
        check("reset_busy",  o_busy,  1'b0);
        check("reset_valid", o_valid, 1'b0);
        check("reset_fail",  o_fail,  1'b0);
        check("reset_err",   o_err,   2'b00);
        check("reset_type",  o_word_type, 1'b0);
        check("reset_data",  o_data,  16'h0000);
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;

        run_word(1'b0, 16'hA5A5, -1, 2'b00, 1'b0, 0, "cmd_a5a5");
        send_hb(1'b0, 0); send_hb(1'b1, 0); send_hb(1'b0, 0); send_hb(1'b1, 0);
        check("noise_busy", o_busy, 1'b0);
        run_word(1'b1, 16'h0001, -1, 2'b00, 1'b0, 0, "dat_0001");
        run_word(1'b0, 16'hFFFF, 5, 2'b11, 1'b0, 0, "manch");
        run_word(1'b0, 16'hA5A5, -1, 2'b00, 1'b1, 0, "parity");

        // clear mid-word, asserted together with a valid half-bit
        send_sync(1'b0, 0, "clr");
        for (int i = 0; i < 10; i++) send_hb((i % 2) == 0, 0);
        i_clear = 1'b1; i_rx_valid = 1'b1; i_rx_in = 1'b1;
        @(posedge i_clk); #1;
        i_clear = 1'b0; i_rx_valid = 1'b0;
        check("clr_busy",  o_busy,  1'b0);
        check("clr_valid", o_valid, 1'b0);
        check("clr_fail",  o_fail,  1'b0);
        check("clr_err",   o_err,   exp_err);
        check("clr_data",  o_data,  exp_data);
        run_word(1'b1, 16'h3C96, -1, 2'b00, 1'b0, 1, "after_clr");

        // asynchronous reset mid-word
        send_sync(1'b1, 0, "rst");
        for (int i = 0; i < 6; i++) send_hb((i % 2) == 0, 0);
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_busy",  o_busy,  1'b0);
        check("rst_valid", o_valid, 1'b0);
        check("rst_fail",  o_fail,  1'b0);
        check("rst_err",   o_err,   2'b00);
        check("rst_type",  o_word_type, 1'b0);
        check("rst_data",  o_data,  16'h0000);
        exp_data = '0; exp_err = 2'b00;
        @(posedge i_clk); #3 i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        run_word(1'b0, 16'h8001, -1, 2'b00, 1'b0, 0, "after_rst");

        for (int it = 0; it < 30; it++) begin
            rd    = DB'($urandom);
            rmode = $urandom_range(0, 3);
            ridx  = (rmode == 1) ? $urandom_range(0, NPAIRS - 1) : -1;
            rbad  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            run_word(1'($urandom_range(0, 1)), rd, ridx, rbad, rmode == 2, 2, "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mil1553_word_rx.md
# mil1553_word_rx

Parametrised MIL-STD-1553 word receiver and successor to the 8-half-bit prefix detector. It consumes a stream of Manchester half-bits and hunts continuously for a command or data sync. After a sync it decodes DATA_BITS data bits and an optional odd-parity bit, then reports the assembled word with its type and an error status. It sits between the half-bit sampler and the word/message layer of the adapter.

## Interface
- DATA_BITS, 16: data bits per word; legal range 1..32.
- SYNC_HALF, 3: half-bits per sync level. The sync window is 2*SYNC_HALF half-bits wide.
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_rx_in  in  1  serial half-bit.
- i_rx_valid  in  1  i_rx_in is valid this cycle; one half-bit per asserted cycle.
- i_clear  in  1  synchronous abort; return to hunting.
- o_busy  out  1  high while a word is being decoded after its sync.
- o_valid  out  1  one-cycle pulse when a word completes without error.
- o_fail  out  1  one-cycle pulse when a word is aborted on error.
- o_err  out  2  error code: 00 none, 01 Manchester, 10 parity. Held until the next o_valid or o_fail.
- o_word_type  out  1  0 = command sync, 1 = data sync. Captured at sync match.
- o_data  out  DATA_BITS  decoded word, MSB first. Held until the next o_valid.

## Operation
- **Sync patterns:**
  - Command sync: SYNC_HALF ones, then SYNC_HALF zeros.
  - Data sync: SYNC_HALF zeros, then SYNC_HALF ones.
- **Manchester encoding:** half-bit pair 10 = 1, 01 = 0. Pairs 00 and 11 are invalid.
- **States:**
  - HUNT: shift each valid half-bit into the sync window and count fill, saturating at 2*SYNC_HALF. When the window is full and matches a sync, latch o_word_type, clear the window, reset the fill count, zero the half-bit counter and go to DATA. No match: stay in HUNT.
  - DATA: count accepted half-bits.
    - On each even half-bit, hold it as the first half.
    - On each odd half-bit, check the pair. Valid: shift the decoded bit into the data register and update running parity. Invalid: go to FAIL with o_err = 01.
    - After 2*DATA_BITS half-bits, go to PAR if MIL1553_RX_PARITY_EN is defined, otherwise to DONE.
  - PAR: take two half-bits.
    - Invalid pair: FAIL with o_err = 01.
    - Total ones across data plus parity even: FAIL with o_err = 10.
    - Otherwise: DONE.
  - DONE: for one cycle, o_valid = 1, load o_data, o_err = 00. Go to HUNT.
  - FAIL: for one cycle, o_fail = 1; o_data is unchanged. Go to HUNT.
- o_busy = 1 in DATA and PAR only.
- **i_clear:** from any state, go to HUNT; clear the window, fill count, half-bit counter and shift register; outputs other than pulses hold. i_clear beats i_rx_valid in the same cycle.
- The half-bit counter is $clog2(2*DATA_BITS+1) bits wide and never wraps.
- Half-bits arriving during DONE or FAIL are dropped.
- **Reset values:** o_busy 0, o_valid 0, o_fail 0, o_err 00, o_word_type 0, o_data 0. State is HUNT, window and counters 0.

## Timing
- Sync match takes effect on the edge that accepts the last sync half-bit; o_busy rises the next cycle.
- Word latency: o_valid or o_fail is asserted the cycle after the edge that accepts the final half-bit, or the offending half-bit.
- A Manchester error is detected on the second half of the bad pair, not at word end.
- Back-to-back words: the first sync half-bit of the next word may arrive two cycles after the final half-bit.
- i_rx_valid may be asserted every cycle or sparsely; gaps do not change the state.
- Reset mid-word: all outputs go to reset values immediately (asynchronous); a partial word is discarded.

## Configuration
- MIL1553_RX_PARITY_EN defined: PAR state present; odd parity over DATA_BITS data bits plus the parity bit is checked; a word is 2*SYNC_HALF + 2*DATA_BITS + 2 half-bits.
- Not defined: PAR state and parity logic are absent; a word is 2*SYNC_HALF + 2*DATA_BITS half-bits; o_err is never 10.

## Test plan
- **Command word:** command sync 111000, then 0xA5A5 as 32 Manchester half-bits, then parity 10. Expect o_valid pulse, o_data = 0xA5A5, o_word_type = 0, o_err = 00.
- **Data word after noise:** noise 0101, then data sync 000111, then 0x0001, then parity 01. Expect o_valid, o_data = 0x0001, o_word_type = 1.
- **Manchester error:** command sync, then 5 good bits, then pair 11. Expect o_fail the cycle after the 11 pair, o_err = 01, o_data holding its previous value, o_busy low next cycle.
- **Parity error:** command sync, 0xA5A5, parity pair 01. Expect o_fail, o_err = 10; with the macro undefined, the same stimulus minus the parity pair gives o_valid.
- **Clear mid-word:** i_clear asserted with i_rx_valid after 10 data half-bits. Expect HUNT and o_busy = 0 next cycle, no o_valid; a following full word decodes correctly.
- **Reset mid-word:** i_reset_n = 0 mid-word. Expect all outputs at reset values immediately; after release, a clean word gives o_valid.
